pic_bus_master: RTL and testbench
=================================

PIC_BUS_MASTER -- requirements
Module: pic_bus_master

Interface
REQ-001 Parameter STROBE_CYCLES, default 2: number of clk cycles WR or RE is held low, legal range 1..15.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  host request present.
REQ-005 cmd_ready  output  1  master idle, accepts request this cycle.
REQ-006 cmd_op  input  2  00 WRITE, 01 READ, 10 INIT, 11 reserved.
REQ-007 cmd_a0  input  1  A0 value for WRITE/READ.
REQ-008 cmd_data  input  8  write byte for WRITE; ICW1 for INIT.
REQ-009 icw2, icw3, icw4  input  8 each  bytes for INIT, sampled at acceptance.
REQ-010 rd_data  output  8  byte captured by READ; rd_valid  output  1  one-cycle pulse with it.
REQ-011 cmd_err  output  1  one-cycle pulse when a request is rejected.
REQ-012 CS, WR, RE  output  1 each  active-low PIC strobes; A0  output  1; D_out  output  8; D_oe  output  1; D_in  input  8.

Function
REQ-013 Handshake: request accepted on a cycle with cmd_valid=1 and cmd_ready=1; cmd_ready=1 only in IDLE.
REQ-014 Each bus access runs SETUP (1 cycle: CS=0, A0 and D_out valid, strobes high) -> STROBE (STROBE_CYCLES cycles: WR=0 for write, RE=0 for read) -> HOLD (1 cycle: strobe high, CS=0, A0/D_out unchanged) -> next access or IDLE.
REQ-015 D_oe=1 from SETUP through HOLD of a write access only; D_oe=0 during reads and IDLE.
REQ-016 READ: D_in sampled on the last STROBE cycle; rd_data updated and rd_valid pulsed on the HOLD cycle; rd_data holds until the next READ.
REQ-017 INIT issues ICW1 (A0=0, cmd_data), ICW2 (A0=1, icw2), then ICW3 (A0=1) only if ICW1 bit1 (SNGL)=0, then ICW4 (A0=1) only if ICW1 bit0 (IC4)=1.
REQ-018 INIT with cmd_data bit4=0 is not a valid ICW1: rejected, cmd_err pulsed, no bus activity, remain IDLE.
REQ-019 cmd_op=11: rejected with cmd_err pulse, no bus activity.
REQ-020 State machine: IDLE, SETUP, STROBE, HOLD, plus 2-bit sequence index ICW1/ICW2/ICW3/ICW4; strobe counter 4 bits, reloads per access, never wraps.
REQ-021 INIT totals: SNGL=1,IC4=0 -> 2 accesses; SNGL=0,IC4=1 -> 4 accesses; each access 2+STROBE_CYCLES cycles.
REQ-022 cmd_valid while busy is ignored; no queuing.
REQ-023 IDLE bus: CS=1, WR=1, RE=1, A0=0, D_out=0x00, D_oe=0.
REQ-024 WR and RE shall never both be 0; strobes change only while CS=0.

Reset
REQ-025 rst asserted at any point, including mid-strobe or mid-INIT, forces IDLE with REQ-023 bus values, cmd_ready=1, rd_data=0x00, rd_valid=0, cmd_err=0 immediately; the aborted sequence is not resumed.

Configuration
REQ-026 Macro PIC_BUS_READ_EN: defined -> READ supported per REQ-016; undefined -> READ rejected with cmd_err, RE tied 1, rd_data constant 0x00, rd_valid constant 0.

Structure
REQ-027 Shared package pic_pkg holds cmd_op encodings, FSM state enum, and ICW1 bit positions (IC4=0, SNGL=1, ICW1 marker=4).
REQ-028 One sub-module pic_bus_cycle performs a single SETUP/STROBE/HOLD access; pic_bus_master sequences it.

Verification
REQ-029 WRITE a0=1 data=0xFB, STROBE_CYCLES=2 -> CS low 4 cycles, WR low cycles 2-3, A0=1, D_out=0xFB, D_oe=1; cmd_ready back after 4 cycles.
REQ-030 INIT cmd_data=0x13 (SNGL=1,IC4=1), icw2=0x20, icw4=0x01 -> bytes 0x13(A0=0), 0x20(A0=1), 0x01(A0=1); no ICW3 access.
REQ-031 INIT cmd_data=0x11, icw2=0x08, icw3=0x04, icw4=0x03 -> four accesses 0x11, 0x08, 0x04, 0x03 in order, 16 cycles total.
REQ-032 READ a0=1 with D_in=0xA5 -> RE low 2 cycles, rd_data=0xA5 with one rd_valid pulse; D_oe stays 0; without PIC_BUS_READ_EN -> cmd_err pulse, RE stays 1.
REQ-033 INIT cmd_data=0x03 -> cmd_err pulse, CS stays 1; cmd_op=11 -> cmd_err pulse.
REQ-034 rst asserted during ICW2 STROBE of an INIT -> CS, WR return to 1 asynchronously, cmd_ready=1; next WRITE runs normally.

Source files
------------

// File: rtl/pic_pkg.sv
// ============================================================================
// Module      : pic_pkg
// Description : Shared command encodings, access-FSM state codes, ICW
//               sequence indices and ICW1 bit positions for the 8259 PIC
//               bus master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pic_pkg;

    localparam logic [1:0] c_op_write = 2'b00;
    localparam logic [1:0] c_op_read  = 2'b01;
    localparam logic [1:0] c_op_init  = 2'b10;
    localparam logic [1:0] c_op_rsvd  = 2'b11;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_strobe = 2'd2;
    localparam logic [1:0] c_st_hold   = 2'd3;

    localparam logic [1:0] c_icw1 = 2'd0;
    localparam logic [1:0] c_icw2 = 2'd1;
    localparam logic [1:0] c_icw3 = 2'd2;
    localparam logic [1:0] c_icw4 = 2'd3;

    localparam int c_icw1_ic4_bit    = 0;
    localparam int c_icw1_sngl_bit   = 1;
    localparam int c_icw1_marker_bit = 4;

    // Returns {more, next_index}; ICW3 exists only in cascade mode, ICW4 only when IC4 is set.
    function automatic logic [2:0] f_next_icw(input logic [1:0] seq, input logic [7:0] icw1);
        logic [2:0] r;
        r = 3'b000;
        case (seq)
            c_icw1: r = {1'b1, c_icw2};
            c_icw2: begin
                if (!icw1[c_icw1_sngl_bit])
                    r = {1'b1, c_icw3};
                else if (icw1[c_icw1_ic4_bit])
                    r = {1'b1, c_icw4};
            end
            c_icw3: begin
                if (icw1[c_icw1_ic4_bit])
                    r = {1'b1, c_icw4};
            end
            default: r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pic_bus_cycle.sv
// ============================================================================
// Module      : pic_bus_cycle
// Description : One SETUP/STROBE/HOLD access on the PIC bus. A new access may
//               be launched from IDLE or directly from HOLD (back-to-back).
//               Read support is compiled in with PIC_BUS_READ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pic_bus_cycle
    import pic_pkg::*;
#(
    parameter int STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       start_write,
    input  logic       start_a0,
    input  logic [7:0] start_data,
    input  logic [7:0] D_in,
    output logic       idle,
    output logic       at_hold,
    output logic       CS,
    output logic       WR,
    output logic       RE,
    output logic       A0,
    output logic [7:0] D_out,
    output logic       D_oe,
    output logic [7:0] rd_data,
    output logic       rd_valid
);

    localparam logic [3:0] c_strobe_load = 4'(STROBE_CYCLES - 1);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [3:0] r_cnt;
    logic       r_write;
    logic       r_a0;
    logic [7:0] r_data;
    logic       w_launch;
    logic       w_strobe;

    assign idle     = (r_state == c_st_idle);
    assign at_hold  = (r_state == c_st_hold);
    assign w_strobe = (r_state == c_st_strobe);
    assign w_launch = start && (idle || at_hold);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= c_st_idle;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:   if (start) w_next_state = c_st_setup;
            c_st_setup:  w_next_state = c_st_strobe;
            c_st_strobe: if (r_cnt == 4'd0) w_next_state = c_st_hold;
            c_st_hold:   w_next_state = start ? c_st_setup : c_st_idle;
            default:     w_next_state = c_st_idle;
        endcase
    end

    // Counter reloads in SETUP so every access gets the full strobe width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_a0    <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            if (r_state == c_st_setup)
                r_cnt <= c_strobe_load;
            else if (w_strobe && (r_cnt != 4'd0))
                r_cnt <= r_cnt - 4'd1;
            if (w_launch) begin
                r_write <= start_write;
                r_a0    <= start_a0;
                r_data  <= start_data;
            end
        end
    end

    assign CS    = idle;
    assign WR    = !(w_strobe && r_write);
    assign A0    = idle ? 1'b0 : r_a0;
    assign D_out = idle ? 8'h00 : r_data;
    assign D_oe  = !idle && r_write;

`ifdef PIC_BUS_READ_EN
    logic [7:0] r_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rd_data <= 8'h00;
        else if (w_strobe && (r_cnt == 4'd0) && !r_write)
            r_rd_data <= D_in;
    end

    assign RE       = !(w_strobe && !r_write);
    assign rd_data  = r_rd_data;
    assign rd_valid = at_hold && !r_write;
`else
    logic [7:0] w_unused_din;
    assign w_unused_din = D_in;
    assign RE       = 1'b1;
    assign rd_data  = 8'h00;
    assign rd_valid = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/pic_bus_master.sv
// ============================================================================
// Module      : pic_bus_master
// Description : Host-side master for an 8259 PIC: WRITE, READ and INIT
//               (ICW1..ICW4 sequence) requests mapped onto bus accesses.
//               Macro PIC_BUS_READ_EN enables READ requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pic_bus_master
    import pic_pkg::*;
#(
    parameter int STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       cmd_err,
    output logic       CS,
    output logic       WR,
    output logic       RE,
    output logic       A0,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic [7:0] D_in
);

    logic       w_idle;
    logic       w_hold;
    logic       w_accept;
    logic       w_op_ok;
    logic [2:0] w_next;
    logic       w_start;
    logic       w_start_write;
    logic       w_start_a0;
    logic [7:0] w_start_data;

    logic       r_init;
    logic [1:0] r_seq;
    logic [7:0] r_icw1;
    logic [7:0] r_icw2;
    logic [7:0] r_icw3;
    logic [7:0] r_icw4;
    logic       r_cmd_err;

    assign cmd_ready = w_idle;
    assign cmd_err   = r_cmd_err;
    assign w_accept  = cmd_valid && w_idle;
    assign w_next    = f_next_icw(r_seq, r_icw1);

    always_comb begin
        w_op_ok = 1'b0;
        case (cmd_op)
            c_op_write: w_op_ok = 1'b1;
`ifdef PIC_BUS_READ_EN
            c_op_read:  w_op_ok = 1'b1;
`else
            c_op_read:  w_op_ok = 1'b0;
`endif
            c_op_init:  w_op_ok = cmd_data[c_icw1_marker_bit];
            default:    w_op_ok = 1'b0;
        endcase
    end

    // Launch either a newly accepted request or the next ICW straight out of HOLD.
    always_comb begin
        w_start       = 1'b0;
        w_start_write = 1'b1;
        w_start_a0    = 1'b0;
        w_start_data  = 8'h00;
        if (w_accept && w_op_ok) begin
            w_start       = 1'b1;
            w_start_write = (cmd_op != c_op_read);
            w_start_a0    = (cmd_op == c_op_init) ? 1'b0 : cmd_a0;
            w_start_data  = (cmd_op == c_op_read) ? 8'h00 : cmd_data;
        end else if (w_hold && r_init && w_next[2]) begin
            w_start    = 1'b1;
            w_start_a0 = 1'b1;
            case (w_next[1:0])
                c_icw2:  w_start_data = r_icw2;
                c_icw3:  w_start_data = r_icw3;
                default: w_start_data = r_icw4;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init    <= 1'b0;
            r_seq     <= c_icw1;
            r_icw1    <= 8'h00;
            r_icw2    <= 8'h00;
            r_icw3    <= 8'h00;
            r_icw4    <= 8'h00;
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= w_accept && !w_op_ok;
            if (w_accept && w_op_ok) begin
                r_init <= (cmd_op == c_op_init);
                r_seq  <= c_icw1;
                r_icw1 <= cmd_data;
                r_icw2 <= icw2;
                r_icw3 <= icw3;
                r_icw4 <= icw4;
            end else if (w_hold && r_init) begin
                if (w_next[2])
                    r_seq <= w_next[1:0];
                else
                    r_init <= 1'b0;
            end
        end
    end

    pic_bus_cycle #(
        .STROBE_CYCLES (STROBE_CYCLES)
    ) u_cycle (
        .clk         (clk),
        .rst         (rst),
        .start       (w_start),
        .start_write (w_start_write),
        .start_a0    (w_start_a0),
        .start_data  (w_start_data),
        .D_in        (D_in),
        .idle        (w_idle),
        .at_hold     (w_hold),
        .CS          (CS),
        .WR          (WR),
        .RE          (RE),
        .A0          (A0),
        .D_out       (D_out),
        .D_oe        (D_oe),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_pic_bus_master.sv
// ============================================================================
// Module      : tb_pic_bus_master
// Description : Directed self-checking bench for pic_bus_master with
//               STROBE_CYCLES = 2 (each access spans 4 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pic_bus_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_a0;
    logic [7:0] cmd_data;
    logic [7:0] icw2, icw3, icw4;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       cmd_err;
    logic       CS, WR, RE, A0, D_oe;
    logic [7:0] D_out;
    logic [7:0] D_in;

    int tests = 0;
    int fails = 0;

    logic       cs_h[0:23], wr_h[0:23], re_h[0:23], a0_h[0:23];
    logic       oe_h[0:23], rdy_h[0:23], err_h[0:23], rv_h[0:23];
    logic [7:0] do_h[0:23], rd_h[0:23];

    pic_bus_master #(.STROBE_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a0    (cmd_a0),
        .cmd_data  (cmd_data),
        .icw2      (icw2),
        .icw3      (icw3),
        .icw4      (icw4),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .cmd_err   (cmd_err),
        .CS        (CS),
        .WR        (WR),
        .RE        (RE),
        .A0        (A0),
        .D_out     (D_out),
        .D_oe      (D_oe),
        .D_in      (D_in)
    );

    always #5 clk = ~clk;

    task automatic sample(input int k);
        cs_h[k]  = CS;   wr_h[k]  = WR;        re_h[k]  = RE;      a0_h[k] = A0;
        oe_h[k]  = D_oe; rdy_h[k] = cmd_ready; err_h[k] = cmd_err; rv_h[k] = rd_valid;
        do_h[k]  = D_out; rd_h[k] = rd_data;
    endtask

    // Index 0 is the acceptance cycle; index k is k cycles after acceptance.
    task automatic issue(input logic [1:0] op, input logic a0, input logic [7:0] d, input int n);
        @(negedge clk);
        sample(0);
        cmd_valid = 1'b1; cmd_op = op; cmd_a0 = a0; cmd_data = d;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a0 = 1'b0; cmd_data = 8'h00;
            end
            sample(k);
        end
    endtask

    task automatic test_reset();
        #12;
        tests++; if ({CS, WR, RE, D_oe, A0} !== 5'b11100) begin fails++; $display("FAIL reset_bus: got %b want 11100", {CS, WR, RE, D_oe, A0}); end
        tests++; if ({cmd_ready, rd_valid, cmd_err} !== 3'b100) begin fails++; $display("FAIL reset_hs: got %b want 100", {cmd_ready, rd_valid, cmd_err}); end
        tests++; if ({rd_data, D_out} !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h want 0000", {rd_data, D_out}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write();
        logic [5:0] cs_v, wr_v, oe_v, rdy_v, re_v;
        issue(2'b00, 1'b1, 8'hFB, 6);
        for (int k = 1; k <= 6; k++) begin
            cs_v[k-1] = cs_h[k]; wr_v[k-1] = wr_h[k]; oe_v[k-1] = oe_h[k];
            rdy_v[k-1] = rdy_h[k]; re_v[k-1] = re_h[k];
        end
        tests++; if (rdy_h[0] !== 1'b1) begin fails++; $display("FAIL write_ready0: got %b want 1", rdy_h[0]); end
        tests++; if (cs_v !== 6'b110000) begin fails++; $display("FAIL write_cs: got %b want 110000", cs_v); end
        tests++; if (wr_v !== 6'b111001) begin fails++; $display("FAIL write_wr: got %b want 111001", wr_v); end
        tests++; if (oe_v !== 6'b001111) begin fails++; $display("FAIL write_oe: got %b want 001111", oe_v); end
        tests++; if (rdy_v !== 6'b110000) begin fails++; $display("FAIL write_ready: got %b want 110000", rdy_v); end
        tests++; if (re_v !== 6'b111111) begin fails++; $display("FAIL write_re: got %b want 111111", re_v); end
        tests++; if ({a0_h[2], do_h[2]} !== {1'b1, 8'hFB}) begin fails++; $display("FAIL write_strobe_bus: got %b/%h want 1/fb", a0_h[2], do_h[2]); end
        tests++; if ({a0_h[4], do_h[4]} !== {1'b1, 8'hFB}) begin fails++; $display("FAIL write_hold_bus: got %b/%h want 1/fb", a0_h[4], do_h[4]); end
        tests++; if ({a0_h[5], do_h[5]} !== 9'h000) begin fails++; $display("FAIL write_idle_bus: got %b/%h want 0/00", a0_h[5], do_h[5]); end
    endtask

    task automatic test_init_no_icw3();
        int wr_low;
        icw2 = 8'h20; icw3 = 8'hEE; icw4 = 8'h01;
        issue(2'b10, 1'b0, 8'h13, 14);
        wr_low = 0;
        for (int k = 1; k <= 14; k++) if (wr_h[k] === 1'b0) wr_low++;
        tests++; if ({a0_h[2], do_h[2], wr_h[2]} !== {1'b0, 8'h13, 1'b0}) begin fails++; $display("FAIL init3_icw1: got %b/%h want 0/13", a0_h[2], do_h[2]); end
        tests++; if ({a0_h[6], do_h[6], wr_h[6]} !== {1'b1, 8'h20, 1'b0}) begin fails++; $display("FAIL init3_icw2: got %b/%h want 1/20", a0_h[6], do_h[6]); end
        tests++; if ({a0_h[10], do_h[10], wr_h[10]} !== {1'b1, 8'h01, 1'b0}) begin fails++; $display("FAIL init3_icw4: got %b/%h want 1/01", a0_h[10], do_h[10]); end
        tests++; if ({cs_h[12], cs_h[13], rdy_h[13]} !== 3'b011) begin fails++; $display("FAIL init3_end: got %b want 011", {cs_h[12], cs_h[13], rdy_h[13]}); end
        tests++; if (wr_low !== 6) begin fails++; $display("FAIL init3_wr_cycles: got %0d want 6", wr_low); end
    endtask

    task automatic test_init_full();
        int cs_low;
        icw2 = 8'h08; icw3 = 8'h04; icw4 = 8'h03;
        issue(2'b10, 1'b0, 8'h11, 17);
        cs_low = 0;
        for (int k = 1; k <= 17; k++) if (cs_h[k] === 1'b0) cs_low++;
        tests++; if ({do_h[2], do_h[6], do_h[10], do_h[14]} !== 32'h11080403) begin fails++; $display("FAIL init4_bytes: got %h want 11080403", {do_h[2], do_h[6], do_h[10], do_h[14]}); end
        tests++; if ({a0_h[2], a0_h[6], a0_h[10], a0_h[14]} !== 4'b0111) begin fails++; $display("FAIL init4_a0: got %b want 0111", {a0_h[2], a0_h[6], a0_h[10], a0_h[14]}); end
        tests++; if (cs_low !== 16) begin fails++; $display("FAIL init4_cycles: got %0d want 16", cs_low); end
        tests++; if ({cs_h[16], cs_h[17], rdy_h[17]} !== 3'b011) begin fails++; $display("FAIL init4_end: got %b want 011", {cs_h[16], cs_h[17], rdy_h[17]}); end
    endtask

    task automatic test_read();
        logic [5:0] re_v, rv_v, oe_v, cs_v;
        D_in = 8'hA5;
        issue(2'b01, 1'b1, 8'h00, 6);
        for (int k = 1; k <= 6; k++) begin
            re_v[k-1] = re_h[k]; rv_v[k-1] = rv_h[k]; oe_v[k-1] = oe_h[k]; cs_v[k-1] = cs_h[k];
        end
        tests++; if (oe_v !== 6'b000000) begin fails++; $display("FAIL read_oe: got %b want 000000", oe_v); end
`ifdef PIC_BUS_READ_EN
        tests++; if (re_v !== 6'b111001) begin fails++; $display("FAIL read_re: got %b want 111001", re_v); end
        tests++; if (rv_v !== 6'b001000) begin fails++; $display("FAIL read_valid: got %b want 001000", rv_v); end
        tests++; if ({rd_h[4], rd_h[6]} !== 16'hA5A5) begin fails++; $display("FAIL read_data: got %h want a5a5", {rd_h[4], rd_h[6]}); end
        tests++; if ({a0_h[2], wr_h[2]} !== 2'b11) begin fails++; $display("FAIL read_a0_wr: got %b want 11", {a0_h[2], wr_h[2]}); end
`else
        tests++; if ({err_h[1], err_h[2]} !== 2'b10) begin fails++; $display("FAIL read_err: got %b want 10", {err_h[1], err_h[2]}); end
        tests++; if (re_v !== 6'b111111) begin fails++; $display("FAIL read_re_tied: got %b want 111111", re_v); end
        tests++; if (cs_v !== 6'b111111) begin fails++; $display("FAIL read_cs: got %b want 111111", cs_v); end
        tests++; if ({rv_v, rd_h[4]} !== 14'h0000) begin fails++; $display("FAIL read_outputs: got %b/%h want 000000/00", rv_v, rd_h[4]); end
`endif
    endtask

    task automatic test_reject();
        issue(2'b10, 1'b0, 8'h03, 4);
        tests++; if ({err_h[0], err_h[1], err_h[2]} !== 3'b010) begin fails++; $display("FAIL bad_icw1_err: got %b want 010", {err_h[0], err_h[1], err_h[2]}); end
        tests++; if ({cs_h[1], cs_h[2], cs_h[3], cs_h[4], rdy_h[2]} !== 5'b11111) begin fails++; $display("FAIL bad_icw1_bus: got %b want 11111", {cs_h[1], cs_h[2], cs_h[3], cs_h[4], rdy_h[2]}); end
        issue(2'b11, 1'b1, 8'h55, 4);
        tests++; if ({err_h[1], err_h[2]} !== 2'b10) begin fails++; $display("FAIL rsvd_err: got %b want 10", {err_h[1], err_h[2]}); end
        tests++; if ({cs_h[1], cs_h[2], wr_h[2], cs_h[3]} !== 4'b1111) begin fails++; $display("FAIL rsvd_bus: got %b want 1111", {cs_h[1], cs_h[2], wr_h[2], cs_h[3]}); end
    endtask

    task automatic test_reset_mid_init();
        icw2 = 8'h08; icw3 = 8'h04; icw4 = 8'h03;
        issue(2'b10, 1'b0, 8'h11, 6);
        tests++; if ({wr_h[6], do_h[6]} !== {1'b0, 8'h08}) begin fails++; $display("FAIL midinit_pre: got %b/%h want 0/08", wr_h[6], do_h[6]); end
        #2 rst = 1'b1;
        #1;
        tests++; if ({CS, WR, RE, D_oe, A0, cmd_ready} !== 6'b111001) begin fails++; $display("FAIL midinit_async: got %b want 111001", {CS, WR, RE, D_oe, A0, cmd_ready}); end
        tests++; if ({rd_data, D_out, rd_valid, cmd_err} !== 18'h0) begin fails++; $display("FAIL midinit_regs: got %h/%h/%b/%b want 00/00/0/0", rd_data, D_out, rd_valid, cmd_err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_after_reset();
        logic [5:0] cs_v, wr_v;
        issue(2'b00, 1'b0, 8'h5C, 6);
        for (int k = 1; k <= 6; k++) begin cs_v[k-1] = cs_h[k]; wr_v[k-1] = wr_h[k]; end
        tests++; if ({cs_h[0], rdy_h[0]} !== 2'b11) begin fails++; $display("FAIL postrst_idle: got %b want 11", {cs_h[0], rdy_h[0]}); end
        tests++; if ({cs_v, wr_v} !== {6'b110000, 6'b111001}) begin fails++; $display("FAIL postrst_strobes: got %b/%b want 110000/111001", cs_v, wr_v); end
        tests++; if ({a0_h[2], do_h[2], oe_h[3]} !== {1'b0, 8'h5C, 1'b1}) begin fails++; $display("FAIL postrst_bus: got %b/%h/%b want 0/5c/1", a0_h[2], do_h[2], oe_h[3]); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a0 = 1'b0; cmd_data = 8'h00;
        icw2 = 8'h00; icw3 = 8'h00; icw4 = 8'h00; D_in = 8'h00;
        test_reset();
        test_write();
        test_init_no_icw3();
        test_init_full();
        test_read();
        test_reject();
        test_reset_mid_init();
        test_write_after_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
